hazard_forward_unit: RTL and testbench

Parametrised forwarding and hazard unit for the five-stage RISC-V pipeline.
- Generates EX-stage operand forwarding selects and the ME-stage store-data forward.
- Detects load-use hazards and raises a one-cycle stall/bubble.
- Tracks one in-flight multi-cycle multiply/divide (MDU) operation with a scoreboard FSM, stalling only dependent or conflicting instructions.
- Counts stall cycles for performance monitoring.

---
 rtl/hazard_forward_unit.sv | 186 ++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding/hazard unit: EX/ME operand forwarding, load-use and MDU
// scoreboard stalls, and a saturating stall-cycle counter.
//
// Ports
//   clk, rst                         clock, async active-high reset
//   id_rs1/id_rs2/id_rd              ID-stage register addresses
//   id_use_rs1/id_use_rs2            ID instruction reads rs1 / rs2
//   id_mdu                           ID instruction is an MDU operation
//   ex_rs1/ex_rs2/ex_rd              EX-stage register addresses
//   ex_memRead                       EX instruction is a load
//   mdu_start                        EX instruction issues to the MDU
//   me_writeReg, me_rd, me_rs2       ME-stage write enable / addresses
//   wb_writeReg, wb_rd               WB-stage write enable / destination
//   flush                            IF/ID squashed this cycle
//   ex_forwardA/ex_forwardB          00 regfile, 01 ME result, 10 WB result
//   me_forwardC                      store data taken from WB result
//   stall_if/stall_id/bubble_ex      hold PC, hold IF/ID, NOP into ID/EX
//   mdu_busy/mdu_done/mdu_done_rd    MDU scoreboard status
//   mdu_overrun                      sticky: mdu_start seen while busy
//   stall_cnt                        saturating count of stalled cycles
module hazard_forward_unit #(
  parameter int AW         = 5,
  parameter int MDU_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_mdu,
  input  logic [AW-1:0]    ex_rs1,
  input  logic [AW-1:0]    ex_rs2,
  input  logic [AW-1:0]    ex_rd,
  input  logic             ex_memRead,
  input  logic             mdu_start,
  input  logic             me_writeReg,
  input  logic [AW-1:0]    me_rd,
  input  logic [AW-1:0]    me_rs2,
  input  logic             wb_writeReg,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  output logic [1:0]       ex_forwardA,
  output logic [1:0]       ex_forwardB,
  output logic             me_forwardC,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [AW-1:0]    mdu_done_rd,
  output logic             mdu_overrun,
  output logic [CNT_W-1:0] stall_cnt
);

  // BUSY lasts MDU_CYCLES-1 cycles, so the down-counter starts at
  // MDU_CYCLES-2 and DONE follows the cycle in which it reads zero.
  localparam int CW = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  mdu_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] pend_rd, pend_rd_nx;

  logic me_wr_ok;
  logic wb_wr_ok;
  logic lu;
  logic mh;
  logic mh_raw;
  logic stall;

  // x0 is hard-wired zero, so a write to it never produces a result
  // worth forwarding.
  assign me_wr_ok = me_writeReg && (me_rd != '0);
  assign wb_wr_ok = wb_writeReg && (wb_rd != '0);

  always_comb begin
    ex_forwardA = 2'b00;
    if (me_wr_ok && (me_rd == ex_rs1)) begin
      ex_forwardA = 2'b01;
    end else if (wb_wr_ok && (wb_rd == ex_rs1)) begin
      ex_forwardA = 2'b10;
    end
  end

  always_comb begin
    ex_forwardB = 2'b00;
    if (me_wr_ok && (me_rd == ex_rs2)) begin
      ex_forwardB = 2'b01;
    end else if (wb_wr_ok && (wb_rd == ex_rs2)) begin
      ex_forwardB = 2'b10;
    end
  end

  assign me_forwardC = wb_wr_ok && (wb_rd == me_rs2);

  assign lu = ex_memRead && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  // RAW on either source or WAW on the destination against the
  // pending MDU result; a second MDU op is a structural conflict.
  assign mh_raw = (pend_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == pend_rd)) ||
                   (id_use_rs2 && (id_rs2 == pend_rd)) ||
                   (id_rd == pend_rd));

  assign mh = mdu_busy && (id_mdu || mh_raw);

  // A flushed ID slot is discarded anyway, so holding it is pointless.
  assign stall     = (lu || mh) && !flush;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall;

  assign mdu_busy    = (state != IDLE);
  assign mdu_done    = (state == DONE);
  assign mdu_done_rd = pend_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_rd <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend_rd <= pend_rd_nx;
    end
  end

  // A start outside IDLE (including DONE) is ignored here and only
  // recorded by the overrun flag.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_rd_nx = pend_rd;
    unique case (state)
      IDLE: begin
        if (mdu_start) begin
          state_nx   = BUSY;
          cnt_nx     = CNT_LOAD;
          pend_rd_nx = ex_rd;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_overrun <= 1'b0;
    end else if (mdu_start && mdu_busy) begin
      mdu_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed scenarios then
// randomized episodes checked against a timestamp-based reference model.
module tb_hazard_forward_unit;
  localparam int AW = 5;
  localparam int M  = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic id_use_rs1, id_use_rs2, id_mdu;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic ex_memRead, mdu_start;
  logic me_writeReg;
  logic [AW-1:0] me_rd, me_rs2;
  logic wb_writeReg;
  logic [AW-1:0] wb_rd;
  logic flush;
  logic [1:0] ex_forwardA, ex_forwardB;
  logic me_forwardC, stall_if, stall_id, bubble_ex;
  logic mdu_busy, mdu_done, mdu_overrun;
  logic [AW-1:0] mdu_done_rd;
  logic [CW-1:0] stall_cnt;

  hazard_forward_unit #(.AW(AW), .MDU_CYCLES(M), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_mdu(id_mdu),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .mdu_start(mdu_start),
    .me_writeReg(me_writeReg), .me_rd(me_rd), .me_rs2(me_rs2),
    .wb_writeReg(wb_writeReg), .wb_rd(wb_rd), .flush(flush),
    .ex_forwardA(ex_forwardA), .ex_forwardB(ex_forwardB),
    .me_forwardC(me_forwardC),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .mdu_done_rd(mdu_done_rd), .mdu_overrun(mdu_overrun),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fa; int fb; int fc; int st;
    int busy; int done; int drd; int ovr; int cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: the MDU op is a timestamp, not a state machine.
  bit have_op;
  int issue, pend, nst, cyc;
  bit ovr;

  function automatic int fsel(int rs);
    if (me_writeReg && me_rd != 0 && int'(me_rd) == rs) return 1;
    if (wb_writeReg && wb_rd != 0 && int'(wb_rd) == rs) return 2;
    return 0;
  endfunction

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_mdu = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_memRead = 0; mdu_start = 0;
    me_writeReg = 0; me_rd = 0; me_rs2 = 0;
    wb_writeReg = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic step();
    exp_t e;
    bit busy, done, lu, mh, st;
    if (rst) begin
      have_op = 0; pend = 0; ovr = 0; nst = 0;
    end
    busy = have_op && cyc > issue && cyc <= issue + M;
    done = have_op && cyc == issue + M;
    lu = ex_memRead && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) ||
          (id_use_rs2 && id_rs2 == ex_rd));
    mh = busy && (id_mdu || (pend != 0 &&
         ((id_use_rs1 && int'(id_rs1) == pend) ||
          (id_use_rs2 && int'(id_rs2) == pend) ||
          int'(id_rd) == pend)));
    st = (lu || mh) && !flush;
    e.fa = fsel(int'(ex_rs1));
    e.fb = fsel(int'(ex_rs2));
    e.fc = (wb_writeReg && wb_rd != 0 && wb_rd == me_rs2) ? 1 : 0;
    e.st = st;
    e.busy = busy;
    e.done = done;
    e.drd = pend;
    e.ovr = ovr;
    e.cnt = (nst > CMAX) ? CMAX : nst;
    q.push_back(e);
    if (!rst) begin
      if (mdu_start) begin
        if (busy) ovr = 1;
        else begin
          have_op = 1; issue = cyc; pend = int'(ex_rd);
        end
      end
      if (st) nst++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwdA", int'(ex_forwardA), e.fa);
      chk("fwdB", int'(ex_forwardB), e.fb);
      chk("fwdC", int'(me_forwardC), e.fc);
      chk("stall_if", int'(stall_if), e.st);
      chk("stall_id", int'(stall_id), e.st);
      chk("bubble_ex", int'(bubble_ex), e.st);
      chk("busy", int'(mdu_busy), e.busy);
      chk("done", int'(mdu_done), e.done);
      chk("done_rd", int'(mdu_done_rd), e.drd);
      chk("overrun", int'(mdu_overrun), e.ovr);
      chk("stall_cnt", int'(stall_cnt), e.cnt);
    end
  end

  initial begin
    int len;
    have_op = 0; issue = 0; pend = 0; nst = 0; cyc = 0; ovr = 0;
    rst = 1;
    clear_in();
    @(posedge clk);
    #1;
    step();
    rst = 0;
    step();

    // forwarding priority and x0
    me_writeReg = 1; wb_writeReg = 1;
    me_rd = 7; wb_rd = 7; ex_rs1 = 7; ex_rs2 = 7;
    step();
    me_writeReg = 0;
    step();
    me_writeReg = 1; me_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    step();
    clear_in();
    wb_writeReg = 1; wb_rd = 4; me_rs2 = 4;
    step();
    clear_in();

    // load-use, then same with flush, then x0 load
    ex_memRead = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    step();
    ex_memRead = 0;
    step();
    ex_memRead = 1; flush = 1;
    step();
    clear_in();
    ex_memRead = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step();
    clear_in();

    // dependent instruction held through DONE
    mdu_start = 1; ex_rd = 9;
    step();
    clear_in();
    id_rs1 = 9; id_use_rs1 = 1;
    repeat (5) step();
    clear_in();

    // independent, structural, WAW + overrun, DONE, IDLE
    mdu_start = 1; ex_rd = 9;
    step();
    clear_in();
    id_rs1 = 3; id_use_rs1 = 1;
    step();
    id_use_rs1 = 0; id_mdu = 1;
    step();
    id_mdu = 0; id_rd = 9; mdu_start = 1;
    step();
    clear_in();
    step();
    step();

    // reset mid-operation
    mdu_start = 1; ex_rd = 9;
    step();
    clear_in();
    id_rd = 9;
    step();
    rst = 1;
    step();
    rst = 0;
    repeat (6) step();

    // counter saturation
    ex_memRead = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    repeat (CMAX + 5) step();
    clear_in();
    rst = 1;
    step();
    rst = 0;

    // randomized episodes
    repeat (40) begin
      len = $urandom_range(10, 60);
      for (int i = 0; i < len; i++) begin
        id_rs1 = AW'($urandom_range(0, 3));
        id_rs2 = AW'($urandom_range(0, 3));
        id_rd = AW'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom_range(0, 1));
        id_use_rs2 = 1'($urandom_range(0, 1));
        id_mdu = ($urandom_range(0, 3) == 0);
        ex_rs1 = AW'($urandom_range(0, 3));
        ex_rs2 = AW'($urandom_range(0, 3));
        ex_rd = AW'($urandom_range(0, 3));
        ex_memRead = ($urandom_range(0, 2) == 0);
        mdu_start = ($urandom_range(0, 5) == 0);
        me_writeReg = 1'($urandom_range(0, 1));
        me_rd = AW'($urandom_range(0, 3));
        me_rs2 = AW'($urandom_range(0, 3));
        wb_writeReg = 1'($urandom_range(0, 1));
        wb_rd = AW'($urandom_range(0, 3));
        flush = ($urandom_range(0, 7) == 0);
        step();
      end
      rst = 1;
      step();
      rst = 0;
    end

    clear_in();
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
